// File: rtl/boreal_mem_pkg.sv
// Shared types and defaults for the boreal memory arbiter slice.
package boreal_mem_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_e;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/boreal_rr_pick.sv
// Combinational round-robin picker: searches upward from last_winner+1 with wrap.
module boreal_rr_pick
  import boreal_mem_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_winner,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = IDX_W'((int'(last_winner) + i) % N_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/boreal_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between N_REQ requesters,
// with a per-access timeout on mem_ready.
module boreal_mem_arbiter
  import boreal_mem_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         req_wr,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
  output logic [N_REQ-1:0]         ack,
  output logic [N_REQ-1:0]         err,
  output logic [DATA_W-1:0]        rdata,
  output logic [N_REQ-1:0]         gnt,
  output logic                     busy,
  output logic                     mem_sel,
  output logic                     mem_wr,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_ready,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int IDX_W = idx_width(N_REQ);
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(N_REQ - 1);

  arb_state_e       state;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] last_winner;
  logic [CNT_W-1:0] cnt;
  logic [N_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0] pick_idx;

  boreal_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req         (req),
    .last_winner (last_winner),
    .grant       (pick_gnt),
    .grant_idx   (pick_idx)
  );

  assign busy = (state != ST_IDLE);

  // Memory side follows the latched winner, so a dropped req cannot disturb the access.
  always_comb begin
    mem_sel   = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == ST_ACCESS) begin
      mem_sel   = 1'b1;
      mem_wr    = req_wr[win_idx];
      mem_addr  = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
      mem_wdata = req_wdata[int'(win_idx)*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      gnt         <= '0;
      ack         <= '0;
      err         <= '0;
      rdata       <= '0;
      cnt         <= '0;
      win_idx     <= '0;
      last_winner <= LAST_RESET;
    end else begin
      ack   <= '0;
      err   <= '0;
      rdata <= '0;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            gnt     <= pick_gnt;
            win_idx <= pick_idx;
            cnt     <= '0;
            state   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // A ready in the final counted cycle still completes the access.
          if (mem_ready) begin
            ack         <= gnt;
            rdata       <= mem_wr ? '0 : mem_rdata;
            last_winner <= win_idx;
            gnt         <= '0;
            state       <= ST_DONE;
          end else if (cnt == CNT_W'(TIMEOUT)) begin
            err         <= gnt;
            last_winner <= win_idx;
            gnt         <= '0;
            state       <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boreal_mem_arbiter.sv
// Self-checking bench: transaction-level round-robin/timeout model against the arbiter.
module tb_boreal_mem_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req, req_wr;
  logic [29:0] req_addr;
  logic [95:0] req_wdata;
  logic [2:0]  ack, err, gnt;
  logic [31:0] rdata;
  logic        busy, mem_sel, mem_wr, mem_ready;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int m_last;
  bit mon_en = 0;

  logic [2:0]  o_gnt, o_ack, o_err, o_done_gnt, o_idle_flags;
  logic        o_busy, o_sel, o_wr, o_done_sel, o_done_busy, o_idle_busy, o_wait_bad;
  logic [9:0]  o_addr;
  logic [31:0] o_wdata, o_rdata, o_idle_rdata;
  int          o_lat, o_abs;
  bit          o_seen;

  boreal_mem_arbiter #(
    .N_REQ(3), .ADDR_W(10), .DATA_W(32), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(ack), .err(err), .rdata(rdata), .gnt(gnt),
    .busy(busy), .mem_sel(mem_sel), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      vectors++;
      if (!$onehot0(gnt) || !$onehot0(ack) || !$onehot0(err) || (|ack && |err) ||
          (mem_sel && !(busy && $onehot(gnt))) || (mem_wr && !mem_sel)) begin
        miscompares++;
        $display("[TB] FAIL invariant: gnt=%b ack=%b err=%b busy=%b sel=%b wr=%b (required legal one-hot set)",
                 gnt, ack, err, busy, mem_sel, mem_wr);
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  // Spec rule: search upward from last+1 with wrap; -1 when nobody asks.
  function automatic int model_pick(input logic [2:0] mask, input int last);
    int c;
    for (int d = 1; d <= 3; d++) begin
      c = (last + d) % 3;
      if (((mask >> c) & 3'b001) != 3'b000) return c;
    end
    return -1;
  endfunction

  function automatic logic [2:0] oh(input int w);
    return (w < 0) ? 3'b000 : (3'b001 << w);
  endfunction

  task automatic randomize_data();
    req_addr  = {10'($urandom), 10'($urandom), 10'($urandom)};
    req_wdata = {$urandom, $urandom, $urandom};
    req_wr    = 3'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    m_last = 2;
  endtask

  // Drives one transaction starting from an IDLE negedge; records observations only.
  task automatic drive_txn(input logic [2:0] req_set, input int delay, input logic [2:0] late_add,
                           input logic [2:0] drop_mask, input logic [31:0] rd_val);
    int t0;
    t0 = cyc;
    req = req_set;
    mem_ready = 1'($urandom);
    mem_rdata = $urandom;
    @(negedge clk);
    o_gnt = gnt; o_busy = busy; o_sel = mem_sel; o_wr = mem_wr; o_addr = mem_addr; o_wdata = mem_wdata;
    req = (req | late_add) & ~drop_mask;
    o_seen = 0; o_wait_bad = 0; o_ack = '0; o_err = '0; o_rdata = '0; o_lat = -1; o_abs = -1;
    o_done_gnt = '1; o_done_sel = 1'b1; o_done_busy = 1'b0;
    for (int k = 0; k <= TO + 2 && !o_seen; k++) begin
      mem_ready = (k == delay);
      mem_rdata = rd_val;
      @(negedge clk);
      if (ack !== 3'b000 || err !== 3'b000) begin
        o_seen = 1; o_ack = ack; o_err = err; o_rdata = rdata; o_lat = cyc - t0; o_abs = cyc;
        o_done_gnt = gnt; o_done_sel = mem_sel; o_done_busy = busy;
      end else if (mem_sel !== 1'b1) begin
        o_wait_bad = 1;
      end
    end
    mem_ready = 1'($urandom);
    req = req & ~(ack | err);
    @(negedge clk);
    o_idle_busy = busy; o_idle_flags = ack | err | gnt; o_idle_rdata = rdata;
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    mem_ready = 1'b1; mem_rdata = '1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({gnt, ack, err} !== 9'd0) begin
      miscompares++; $display("[TB] FAIL reset_flags: got %b required 0", {gnt, ack, err});
    end
    vectors++;
    if (rdata !== 32'd0) begin
      miscompares++; $display("[TB] FAIL reset_rdata: got %h required 0", rdata);
    end
    vectors++;
    if ({busy, mem_sel} !== 2'b00) begin
      miscompares++; $display("[TB] FAIL reset_busy_sel: got %b required 00", {busy, mem_sel});
    end
    rst_n = 1'b1; m_last = 2; mon_en = 1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, ack, err, mem_sel} !== 8'd0) begin
      miscompares++; $display("[TB] FAIL idle_ready_ignored: got %b required 0", {busy, ack, err, mem_sel});
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_single_read();
    randomize_data();
    req_addr[9:0] = 10'h010;
    req_wr[0] = 1'b0;
    drive_txn(3'b001, 0, 3'b000, 3'b000, 32'hDEADBEEF);
    vectors++;
    if ({o_gnt, o_sel, o_wr, o_addr} !== {3'b001, 1'b1, 1'b0, 10'h010}) begin
      miscompares++; $display("[TB] FAIL read_access: got gnt=%b sel=%b wr=%b addr=%h required 001/1/0/010",
                              o_gnt, o_sel, o_wr, o_addr);
    end
    vectors++;
    if ({o_ack, o_err, o_rdata} !== {3'b001, 3'b000, 32'hDEADBEEF}) begin
      miscompares++; $display("[TB] FAIL read_ack: got ack=%b err=%b rdata=%h required 001/000/deadbeef",
                              o_ack, o_err, o_rdata);
    end
    vectors++;
    if (o_lat !== 2) begin
      miscompares++; $display("[TB] FAIL read_latency: got %0d required 2", o_lat);
    end
    vectors++;
    if ({o_done_gnt, o_done_sel, o_done_busy, o_idle_busy, o_idle_rdata} !== {3'b000, 1'b0, 1'b1, 1'b0, 32'd0}) begin
      miscompares++; $display("[TB] FAIL read_done_idle: got gnt=%b sel=%b busy=%b idle_busy=%b idle_rdata=%h required 000/0/1/0/0",
                              o_done_gnt, o_done_sel, o_done_busy, o_idle_busy, o_idle_rdata);
    end
    m_last = 0;
  endtask

  task automatic test_write();
    int w;
    randomize_data();
    req_wr = 3'b010;
    req_addr[19:10] = 10'h3FF;
    req_wdata[63:32] = 32'hA5A5A5A5;
    w = model_pick(3'b010, m_last);
    drive_txn(3'b010, 1, 3'b000, 3'b000, 32'h12345678);
    vectors++;
    if ({o_gnt, o_sel, o_wr, o_addr, o_wdata} !== {oh(w), 1'b1, 1'b1, 10'h3FF, 32'hA5A5A5A5}) begin
      miscompares++; $display("[TB] FAIL write_access: got gnt=%b sel=%b wr=%b addr=%h wdata=%h required %b/1/1/3ff/a5a5a5a5",
                              o_gnt, o_sel, o_wr, o_addr, o_wdata, oh(w));
    end
    vectors++;
    if ({o_ack, o_rdata, o_lat} !== {oh(w), 32'd0, 32'd3}) begin
      miscompares++; $display("[TB] FAIL write_ack: got ack=%b rdata=%h lat=%0d required %b/0/3",
                              o_ack, o_rdata, o_lat, oh(w));
    end
    m_last = w;
  endtask

  task automatic test_back_to_back();
    int prev_abs;
    prev_abs = 0;
    do_reset();
    for (int j = 0; j < 4; j++) begin
      randomize_data();
      drive_txn(3'b111, 0, 3'b000, 3'b000, $urandom);
      vectors++;
      if ({o_gnt, o_ack} !== {oh(j % 3), oh(j % 3)}) begin
        miscompares++; $display("[TB] FAIL b2b_order[%0d]: got gnt=%b ack=%b required %b", j, o_gnt, o_ack, oh(j % 3));
      end
      if (j > 0) begin
        vectors++;
        if (o_abs - prev_abs !== 3) begin
          miscompares++; $display("[TB] FAIL b2b_spacing[%0d]: got %0d cycles required 3", j, o_abs - prev_abs);
        end
      end
      prev_abs = o_abs;
      m_last = j % 3;
    end
  endtask

  task automatic test_timeout();
    int w;
    randomize_data();
    w = model_pick(3'b101, m_last);
    drive_txn(3'b101, -1, 3'b000, 3'b000, $urandom);
    vectors++;
    if ({o_gnt, o_err, o_ack, o_rdata} !== {oh(w), oh(w), 3'b000, 32'd0}) begin
      miscompares++; $display("[TB] FAIL timeout_err: got gnt=%b err=%b ack=%b rdata=%h required %b/%b/000/0",
                              o_gnt, o_err, o_ack, o_rdata, oh(w), oh(w));
    end
    vectors++;
    if (o_lat !== TO + 2 || o_wait_bad !== 1'b0) begin
      miscompares++; $display("[TB] FAIL timeout_latency: got lat=%0d sel_drop=%b required %0d/0", o_lat, o_wait_bad, TO + 2);
    end
    m_last = w;
    w = model_pick(3'b101 & ~oh(w), m_last);
    drive_txn(3'b101 & ~oh(m_last), 2, 3'b000, 3'b000, $urandom);
    vectors++;
    if ({o_gnt, o_ack, o_lat} !== {oh(w), oh(w), 32'd4}) begin
      miscompares++; $display("[TB] FAIL timeout_next: got gnt=%b ack=%b lat=%0d required %b/%b/4",
                              o_gnt, o_ack, o_lat, oh(w), oh(w));
    end
    m_last = w;
    w = model_pick(3'b010, m_last);
    drive_txn(3'b010, TO, 3'b000, 3'b000, $urandom);
    vectors++;
    if ({o_ack, o_err, o_lat} !== {oh(w), 3'b000, 32'(TO + 2)}) begin
      miscompares++; $display("[TB] FAIL timeout_edge_ready: got ack=%b err=%b lat=%0d required %b/000/%0d",
                              o_ack, o_err, o_lat, oh(w), TO + 2);
    end
    m_last = w;
  endtask

  task automatic test_req_drop();
    int w;
    logic [2:0] pend;
    randomize_data();
    w = model_pick(3'b011, m_last);
    drive_txn(3'b011, 1, 3'b100, oh(w), $urandom);
    vectors++;
    if ({o_gnt, o_ack, o_err} !== {oh(w), oh(w), 3'b000}) begin
      miscompares++; $display("[TB] FAIL drop_completes: got gnt=%b ack=%b err=%b required %b/%b/000",
                              o_gnt, o_ack, o_err, oh(w), oh(w));
    end
    m_last = w;
    pend = (3'b011 | 3'b100) & ~oh(w);
    w = model_pick(pend, m_last);
    drive_txn(pend, 0, 3'b000, 3'b000, $urandom);
    vectors++;
    if ({o_gnt, o_ack} !== {oh(w), oh(w)}) begin
      miscompares++; $display("[TB] FAIL held_req_served: got gnt=%b ack=%b required %b", o_gnt, o_ack, oh(w));
    end
    m_last = w;
  endtask

  task automatic test_reset_mid_access();
    int w;
    randomize_data();
    w = model_pick(3'b110, m_last);
    req = 3'b110;
    mem_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if ({gnt, mem_sel} !== {oh(w), 1'b1}) begin
      miscompares++; $display("[TB] FAIL midrst_pre: got gnt=%b sel=%b required %b/1", gnt, mem_sel, oh(w));
    end
    rst_n = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if ({mem_sel, gnt, busy, ack, err} !== 11'd0) begin
      miscompares++; $display("[TB] FAIL midrst_drop: got sel=%b gnt=%b busy=%b ack=%b err=%b required all 0",
                              mem_sel, gnt, busy, ack, err);
    end
    rst_n = 1'b1; req = '0; mem_ready = 1'b0; m_last = 2;
    @(negedge clk);
    drive_txn(3'b111, 0, 3'b000, 3'b000, $urandom);
    vectors++;
    if ({o_gnt, o_ack} !== {3'b001, 3'b001}) begin
      miscompares++; $display("[TB] FAIL midrst_next: got gnt=%b ack=%b required 001/001", o_gnt, o_ack);
    end
    m_last = 0;
  endtask

  task automatic test_random();
    logic [2:0]  pending, late, eg;
    logic [31:0] rdv, exp_rd;
    int delay, w, exp_lat;
    bit exp_ok, wr_w;
    pending = req;
    for (int it = 0; it < 40; it++) begin
      pending |= 3'($urandom) & 3'($urandom);
      if (pending == 3'b000) pending = oh($urandom_range(0, 2));
      randomize_data();
      case ($urandom_range(0, 7))
        7: delay = -1;
        6: delay = TO;
        5: delay = TO + 1;
        default: delay = $urandom_range(0, 3);
      endcase
      late = 3'($urandom) & 3'($urandom) & ~pending;
      rdv = $urandom;
      w = model_pick(pending, m_last);
      eg = oh(w);
      wr_w = ((req_wr >> w) & 3'b001) != 3'b000;
      exp_ok = (delay >= 0) && (delay <= TO);
      exp_lat = exp_ok ? delay + 2 : TO + 2;
      exp_rd = (exp_ok && !wr_w) ? rdv : 32'd0;
      drive_txn(pending, delay, late, 3'b000, rdv);
      vectors++;
      if ({o_gnt, o_sel, o_wr, o_addr, o_wdata} !==
          {eg, 1'b1, wr_w, 10'(req_addr >> (w * 10)), 32'(req_wdata >> (w * 32))}) begin
        miscompares++; $display("[TB] FAIL rand_access[%0d]: got gnt=%b wr=%b addr=%h wdata=%h required gnt=%b wr=%b addr=%h wdata=%h",
                                it, o_gnt, o_wr, o_addr, o_wdata, eg, wr_w, 10'(req_addr >> (w * 10)), 32'(req_wdata >> (w * 32)));
      end
      vectors++;
      if ({o_ack, o_err, o_rdata, o_lat} !== {(exp_ok ? eg : 3'b000), (exp_ok ? 3'b000 : eg), exp_rd, 32'(exp_lat)}) begin
        miscompares++; $display("[TB] FAIL rand_outcome[%0d]: got ack=%b err=%b rdata=%h lat=%0d required ack=%b err=%b rdata=%h lat=%0d",
                                it, o_ack, o_err, o_rdata, o_lat, (exp_ok ? eg : 3'b000), (exp_ok ? 3'b000 : eg), exp_rd, exp_lat);
      end
      vectors++;
      if ({o_wait_bad, o_done_gnt, o_done_sel, o_done_busy, o_idle_busy, o_idle_flags} !== {1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 3'b000}) begin
        miscompares++; $display("[TB] FAIL rand_done_idle[%0d]: got seldrop=%b gnt=%b sel=%b busy=%b idle_busy=%b idle=%b required 0/000/0/1/0/000",
                                it, o_wait_bad, o_done_gnt, o_done_sel, o_done_busy, o_idle_busy, o_idle_flags);
      end
      m_last = w;
      pending = (pending | late) & ~eg;
    end
  endtask

  initial begin
    $display("[TB] boreal_mem_arbiter bench start");
    test_reset();
    test_single_read();
    test_write();
    test_back_to_back();
    test_timeout();
    test_req_drop();
    test_reset_mid_access();
    test_random();
    mon_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
